// File: rtl/hc595_chain_ctrl_pkg.sv
// Shared definitions for the 74HC595 chain driver.
// Holds the FSM state encoding, a constant clog2 helper and the legal
// parameter ranges used by the top-level elaboration check.
package hc595_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2
    } hc595_state_e;

    localparam int DATA_W_MIN = 2;
    localparam int DATA_W_MAX = 64;
    localparam int DIV_MIN    = 1;

    // Smallest r with 2**r >= value; used for counter widths.
    function automatic int hc595_clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic bit hc595_params_ok(input int data_w, input int div);
        return (data_w >= DATA_W_MIN) && (data_w <= DATA_W_MAX) && (div >= DIV_MIN);
    endfunction

endpackage

// File: rtl/hc595_chain_ctrl_if.sv
// Handshake and pin bundle between the formatting logic (master) and the
// 595 chain driver (slave).
//   data_in, load              : word offer from the master
//   busy, pend_full, done      : status back to the master
//   stcp, shcp, ds, oe         : board-level 595 pins driven by the slave
interface hc595_chain_ctrl_if #(
    parameter int DATA_W = 14
);
    logic [DATA_W-1:0] data_in;
    logic              load;
    logic              busy;
    logic              pend_full;
    logic              done;
    logic              stcp;
    logic              shcp;
    logic              ds;
    logic              oe;

    modport master (
        output data_in, load,
        input  busy, pend_full, done, stcp, shcp, ds, oe
    );

    modport slave (
        input  data_in, load,
        output busy, pend_full, done, stcp, shcp, ds, oe
    );
endinterface

// File: rtl/hc595_chain_ctrl_bit_timer.sv
// Bit-rate timer for the 595 chain driver.
//   sys_clk, sys_rst_n : clock, async active-low reset
//   clr_i              : hold both counters at zero
//   shift_en_i         : count a bit period (0..2*DIV-1) and advance cnt_bit
//   latch_en_i         : count the latch window (0..DIV-1)
//   cnt_bit_o          : number of the bit currently being sent
//   last_bit_o         : final cycle of the final bit
//   shcp_rise_o        : mid-bit cycle where shcp must go high
//   ds_update_o        : first cycle of a bit, where ds takes the new value
//   latch_end_o        : final cycle of the latch window
module hc595_bit_timer
    import hc595_pkg::*;
#(
    parameter int DATA_W = 14,
    parameter int DIV    = 2,
    localparam int CW_DIV = hc595_clog2(2 * DIV),
    localparam int CW_BIT = hc595_clog2(DATA_W)
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              clr_i,
    input  logic              shift_en_i,
    input  logic              latch_en_i,
    output logic [CW_BIT-1:0] cnt_bit_o,
    output logic              last_bit_o,
    output logic              shcp_rise_o,
    output logic              ds_update_o,
    output logic              latch_end_o
);

    localparam logic [CW_DIV-1:0] DIV_WRAP   = CW_DIV'(2 * DIV - 1);
    localparam logic [CW_DIV-1:0] DIV_HALF   = CW_DIV'(DIV);
    localparam logic [CW_DIV-1:0] LATCH_LAST = CW_DIV'(DIV - 1);
    localparam logic [CW_BIT-1:0] BIT_LAST   = CW_BIT'(DATA_W - 1);

    logic [CW_DIV-1:0] cnt_div_q, cnt_div_d;
    logic [CW_BIT-1:0] cnt_bit_q, cnt_bit_d;

    always_comb begin
        cnt_div_d = cnt_div_q;
        cnt_bit_d = cnt_bit_q;
        if (clr_i) begin
            cnt_div_d = '0;
            cnt_bit_d = '0;
        end else if (shift_en_i) begin
            if (cnt_div_q == DIV_WRAP) begin
                cnt_div_d = '0;
                // Wrapping on the last bit leaves both counters at zero for
                // the latch window and the following frame.
                cnt_bit_d = (cnt_bit_q == BIT_LAST) ? '0 : cnt_bit_q + 1'b1;
            end else begin
                cnt_div_d = cnt_div_q + 1'b1;
            end
        end else if (latch_en_i) begin
            cnt_div_d = (cnt_div_q == LATCH_LAST) ? '0 : cnt_div_q + 1'b1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_div_q <= '0;
            cnt_bit_q <= '0;
        end else begin
            cnt_div_q <= cnt_div_d;
            cnt_bit_q <= cnt_bit_d;
        end
    end

    assign cnt_bit_o   = cnt_bit_q;
    assign last_bit_o  = shift_en_i && (cnt_div_q == DIV_WRAP) && (cnt_bit_q == BIT_LAST);
    assign shcp_rise_o = shift_en_i && (cnt_div_q == DIV_HALF);
    assign ds_update_o = shift_en_i && (cnt_div_q == '0);
    assign latch_end_o = latch_en_i && (cnt_div_q == LATCH_LAST);

endmodule

// File: rtl/hc595_chain_ctrl.sv
// Serial driver for a daisy chain of 74HC595 shift registers.
// Accepts a DATA_W-bit word on a load/busy handshake, buffers one pending
// word, shifts it out on ds/shcp at 2*DIV cycles per bit and pulses stcp.
//   sys_clk, sys_rst_n : clock, async active-low reset
//   bus (slave)        : data_in/load in; busy, pend_full, done, stcp,
//                        shcp, ds, oe out (all registered)
//
// state  | meaning
// IDLE   | no frame in progress, waiting for load
// SHIFT  | sending bits on ds, one shcp pulse per bit
// LATCH  | stcp high for DIV cycles, then decide the next frame
module hc595_chain_ctrl
    import hc595_pkg::*;
#(
    parameter int DATA_W     = 14,
    parameter int DIV        = 2,
    parameter bit MSB_FIRST  = 1'b0,
    parameter bit CONTINUOUS = 1'b0
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    hc595_chain_ctrl_if.slave   bus
);

    localparam int CW_BIT = hc595_clog2(DATA_W);
    localparam logic [CW_BIT-1:0] BIT_LAST = CW_BIT'(DATA_W - 1);

    if (!hc595_params_ok(DATA_W, DIV)) begin : g_bad_params
        $error("hc595_chain_ctrl: DATA_W must be 2..64 and DIV must be >= 1");
    end

    hc595_state_e      state_q, state_d;
    logic [DATA_W-1:0] shift_buf_q, shift_buf_d;
    logic [DATA_W-1:0] pend_buf_q, pend_buf_d;
    logic              pend_full_q, pend_full_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              stcp_q, stcp_d;
    logic              shcp_q, shcp_d;
    logic              ds_q, ds_d;
    logic              oe_q, oe_d;

    logic [CW_BIT-1:0] cnt_bit;
    logic [CW_BIT-1:0] bit_idx;
    logic              last_bit;
    logic              shcp_rise;
    logic              ds_update;
    logic              latch_end;
    logic              accept;

    hc595_bit_timer #(
        .DATA_W (DATA_W),
        .DIV    (DIV)
    ) u_bit_timer (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .clr_i       (state_q == ST_IDLE),
        .shift_en_i  (state_q == ST_SHIFT),
        .latch_en_i  (state_q == ST_LATCH),
        .cnt_bit_o   (cnt_bit),
        .last_bit_o  (last_bit),
        .shcp_rise_o (shcp_rise),
        .ds_update_o (ds_update),
        .latch_end_o (latch_end)
    );

    assign accept  = bus.load && !pend_full_q;
    assign bit_idx = MSB_FIRST ? (BIT_LAST - cnt_bit) : cnt_bit;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= ST_IDLE;
            shift_buf_q <= '0;
            pend_buf_q  <= '0;
            pend_full_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            stcp_q      <= 1'b0;
            shcp_q      <= 1'b0;
            ds_q        <= 1'b0;
            oe_q        <= 1'b1;
        end else begin
            state_q     <= state_d;
            shift_buf_q <= shift_buf_d;
            pend_buf_q  <= pend_buf_d;
            pend_full_q <= pend_full_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            stcp_q      <= stcp_d;
            shcp_q      <= shcp_d;
            ds_q        <= ds_d;
            oe_q        <= oe_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        shift_buf_d = shift_buf_q;
        pend_buf_d  = pend_buf_q;
        pend_full_d = pend_full_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.load) begin
                    shift_buf_d = bus.data_in;
                    state_d     = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (accept) begin
                    pend_buf_d  = bus.data_in;
                    pend_full_d = 1'b1;
                end
                if (last_bit) begin
                    state_d = ST_LATCH;
                end
            end
            ST_LATCH: begin
                if (latch_end) begin
                    if (pend_full_q) begin
                        shift_buf_d = pend_buf_q;
                        pend_full_d = 1'b0;
                        state_d     = ST_SHIFT;
                    end else if (bus.load) begin
                        // Word arriving exactly at the boundary skips the
                        // pending buffer and starts the next frame directly.
                        shift_buf_d = bus.data_in;
                        state_d     = ST_SHIFT;
                    end else if (CONTINUOUS) begin
                        state_d = ST_SHIFT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (accept) begin
                    pend_buf_d  = bus.data_in;
                    pend_full_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_d = (state_d != ST_IDLE);
        done_d = latch_end;
        stcp_d = (state_q == ST_LATCH);
        ds_d   = ds_q;
        if (ds_update) begin
            ds_d = shift_buf_q[bit_idx];
        end
        // shcp rises mid-bit and falls together with the next ds change;
        // the latch window forces it low so stcp never overlaps a shift.
        shcp_d = shcp_q;
        if (state_q != ST_SHIFT) begin
            shcp_d = 1'b0;
        end else if (shcp_rise) begin
            shcp_d = 1'b1;
        end else if (ds_update) begin
            shcp_d = 1'b0;
        end
        // Outputs stay disabled until a complete frame has been latched.
        oe_d = oe_q && !latch_end;
    end

    assign bus.busy      = busy_q;
    assign bus.pend_full = pend_full_q;
    assign bus.done      = done_q;
    assign bus.stcp      = stcp_q;
    assign bus.shcp      = shcp_q;
    assign bus.ds        = ds_q;
    assign bus.oe        = oe_q;

endmodule

// File: tb/tb_hc595_chain_ctrl.sv
// Bench for hc595_chain_ctrl: three instances (default, MSB-first 16-bit
// DIV=1, continuous) watched by a pin-level model of a chained 595.
module tb_hc595_chain_ctrl;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    hc595_chain_ctrl_if #(.DATA_W(14)) bus0 ();
    hc595_chain_ctrl_if #(.DATA_W(16)) bus1 ();
    hc595_chain_ctrl_if #(.DATA_W(14)) bus2 ();

    hc595_chain_ctrl #(.DATA_W(14), .DIV(2), .MSB_FIRST(1'b0), .CONTINUOUS(1'b0)) dut0 (
        .sys_clk(clk), .sys_rst_n(rst_n), .bus(bus0.slave));
    hc595_chain_ctrl #(.DATA_W(16), .DIV(1), .MSB_FIRST(1'b1), .CONTINUOUS(1'b0)) dut1 (
        .sys_clk(clk), .sys_rst_n(rst_n), .bus(bus1.slave));
    hc595_chain_ctrl #(.DATA_W(14), .DIV(2), .MSB_FIRST(1'b0), .CONTINUOUS(1'b1)) dut2 (
        .sys_clk(clk), .sys_rst_n(rst_n), .bus(bus2.slave));

    int wd   [3] = '{14, 16, 14};
    int dv   [3] = '{2, 1, 2};
    bit msbf [3] = '{1'b0, 1'b1, 1'b0};

    logic [2:0] shcp_v, stcp_v, ds_v, done_v, busy_v, oe_v;
    assign shcp_v = {bus2.shcp, bus1.shcp, bus0.shcp};
    assign stcp_v = {bus2.stcp, bus1.stcp, bus0.stcp};
    assign ds_v   = {bus2.ds,   bus1.ds,   bus0.ds};
    assign done_v = {bus2.done, bus1.done, bus0.done};
    assign busy_v = {bus2.busy, bus1.busy, bus0.busy};
    assign oe_v   = {bus2.oe,   bus1.oe,   bus0.oe};

    typedef struct {
        int          d;
        logic [63:0] word;
        int          done_cyc;
        int          rises;
        int          stcp_len;
        int          first_rise;
        logic        oe_before;
        logic        oe_at_done;
        logic        busy_at_done;
        logic        pend_at_done;
    } frame_t;

    frame_t      fq[$];
    frame_t      mf;
    logic [63:0] sr      [3];
    logic [63:0] latched [3];
    int          rises   [3];
    int          frise   [3];
    int          slen    [3];
    int          tot_rises [3];
    int          busy_low  [3];
    bit          watch   [3];
    logic [2:0]  shcp_p, stcp_p, oe_p;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // First bit shifted ends deepest in the chain; bit number k carries
    // data[k] (LSB first) or data[w-1-k] (MSB first).
    function automatic logic [63:0] decode(input logic [63:0] s, input int w, input bit m);
        logic [63:0] r;
        r = '0;
        for (int k = 0; k < w; k++) begin
            int idx;
            idx = m ? (w - 1 - k) : k;
            r[idx] = s[w - 1 - k];
        end
        return r;
    endfunction

    function automatic int flen(input int d);
        return 2 * dv[d] * wd[d] + dv[d];
    endfunction

    function automatic logic [6:0] pins(input int d);
        case (d)
            0: return {bus0.busy, bus0.pend_full, bus0.done, bus0.stcp, bus0.shcp, bus0.ds, bus0.oe};
            1: return {bus1.busy, bus1.pend_full, bus1.done, bus1.stcp, bus1.shcp, bus1.ds, bus1.oe};
            default: return {bus2.busy, bus2.pend_full, bus2.done, bus2.stcp, bus2.shcp, bus2.ds, bus2.oe};
        endcase
    endfunction

    function automatic logic pend(input int d);
        case (d)
            0: return bus0.pend_full;
            1: return bus1.pend_full;
            default: return bus2.pend_full;
        endcase
    endfunction

    // Chained-595 model: shift on shcp rise, latch on stcp rise.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (!rst_n) begin
                sr[d] = '0; rises[d] = 0; slen[d] = 0; frise[d] = 0;
            end else begin
                if (shcp_v[d] && !shcp_p[d]) begin
                    sr[d] = {sr[d][62:0], ds_v[d]};
                    if (rises[d] == 0) frise[d] = cyc;
                    rises[d]++;
                    tot_rises[d]++;
                end
                if (stcp_v[d]) begin
                    if (!stcp_p[d]) begin
                        latched[d] = sr[d];
                        slen[d] = 1;
                    end else begin
                        slen[d]++;
                    end
                end
                if (watch[d] && !busy_v[d]) busy_low[d]++;
                if (done_v[d]) begin
                    mf.d            = d;
                    mf.word         = decode(latched[d], wd[d], msbf[d]);
                    mf.done_cyc     = cyc;
                    mf.rises        = rises[d];
                    mf.stcp_len     = slen[d];
                    mf.first_rise   = frise[d];
                    mf.oe_before    = oe_p[d];
                    mf.oe_at_done   = oe_v[d];
                    mf.busy_at_done = busy_v[d];
                    mf.pend_at_done = pend(d);
                    fq.push_back(mf);
                    rises[d] = 0;
                end
            end
            shcp_p[d] = shcp_v[d];
            stcp_p[d] = stcp_v[d];
            oe_p[d]   = oe_v[d];
        end
    end

    // Called at a falling edge; the word is accepted on the next rising edge.
    task automatic drive_load(input int d, input logic [63:0] word, output int e0);
        e0 = cyc + 1;
        case (d)
            0: begin bus0.data_in = word[13:0]; bus0.load = 1'b1; end
            1: begin bus1.data_in = word[15:0]; bus1.load = 1'b1; end
            default: begin bus2.data_in = word[13:0]; bus2.load = 1'b1; end
        endcase
        @(negedge clk);
        bus0.load = 1'b0; bus1.load = 1'b0; bus2.load = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic int count_frames(input int d);
        int n;
        n = 0;
        foreach (fq[i]) if (fq[i].d == d) n++;
        return n;
    endfunction

    task automatic get_frame(input int d, output frame_t f, output bit ok);
        int idx;
        ok = 1'b0;
        f = '{default: '0};
        for (int t = 0; t < 300 && !ok; t++) begin
            idx = -1;
            for (int i = 0; i < fq.size(); i++) if (idx < 0 && fq[i].d == d) idx = i;
            if (idx >= 0) begin
                f = fq[idx];
                fq.delete(idx);
                ok = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        if (!ok) chk("frame_timeout", 0, 1);
    endtask

    task automatic check_frame(input string tag, input frame_t f, input int d,
                               input logic [63:0] word, input int start);
        chk({tag, "_word"},      f.word,       word);
        chk({tag, "_done_cyc"},  f.done_cyc,   start + flen(d));
        chk({tag, "_shcp_rises"},f.rises,      wd[d]);
        chk({tag, "_stcp_len"},  f.stcp_len,   dv[d]);
        chk({tag, "_first_rise"},f.first_rise, start + 1 + dv[d]);
        chk({tag, "_oe_at_done"},f.oe_at_done, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        frame_t      f;
        bit          ok;
        int          e0, e_tmp;
        logic [63:0] w, w2, w3, mask;
        int          r0, r2;

        for (int d = 0; d < 3; d++) begin
            tot_rises[d] = 0; busy_low[d] = 0; watch[d] = 1'b0;
        end
        bus0.load = 1'b0; bus1.load = 1'b0; bus2.load = 1'b0;
        bus0.data_in = '0; bus1.data_in = '0; bus2.data_in = '0;
        wait_cycles(3);
        rst_n = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 3; d++) chk("reset_pins", pins(d), 7'b0000001);

        // Default instance: known word, then random words.
        drive_load(0, 64'h2A5F, e0);
        chk("t1_busy_after_load", bus0.busy, 1'b1);
        get_frame(0, f, ok);
        check_frame("t1", f, 0, 64'h2A5F, e0);
        chk("t1_oe_before_first_done", f.oe_before, 1'b1);
        chk("t1_busy_drops_with_done", f.busy_at_done, 1'b0);
        mask = (64'd1 << wd[0]) - 1;
        repeat (3) begin
            wait_cycles($urandom_range(1, 5));
            w = {$urandom, $urandom} & mask;
            drive_load(0, w, e0);
            get_frame(0, f, ok);
            check_frame("t1r", f, 0, w, e0);
            chk("t1r_oe_stays_low", f.oe_before, 1'b0);
            chk("t1r_busy_at_done", f.busy_at_done, 1'b0);
        end

        // MSB-first 16-bit, DIV=1.
        wait_cycles(2);
        drive_load(1, 64'hA5C3, e0);
        get_frame(1, f, ok);
        check_frame("t2", f, 1, 64'hA5C3, e0);
        mask = (64'd1 << wd[1]) - 1;
        repeat (3) begin
            wait_cycles($urandom_range(1, 5));
            w = {$urandom, $urandom} & mask;
            drive_load(1, w, e0);
            get_frame(1, f, ok);
            check_frame("t2r", f, 1, w, e0);
        end

        // Pending buffer: second load queued, third load dropped.
        wait_cycles(3);
        mask = (64'd1 << wd[0]) - 1;
        w  = {$urandom, $urandom} & mask;
        w3 = ~64'h1234 & mask;
        drive_load(0, w, e0);
        wait_cycles(9);
        drive_load(0, 64'h1234, e_tmp);
        chk("t3_pend_set", bus0.pend_full, 1'b1);
        wait_cycles(9);
        drive_load(0, w3, e_tmp);
        chk("t3_pend_held_on_drop", bus0.pend_full, 1'b1);
        chk("t3_busy_mid", bus0.busy, 1'b1);
        get_frame(0, f, ok);
        check_frame("t3a", f, 0, w, e0);
        chk("t3a_pend_cleared", f.pend_at_done, 1'b0);
        chk("t3a_busy_held", f.busy_at_done, 1'b1);
        get_frame(0, f, ok);
        check_frame("t3b", f, 0, 64'h1234, e0 + flen(0));
        chk("t3b_busy_drops", f.busy_at_done, 1'b0);
        wait_cycles(150);
        chk("t3_dropped_word_not_sent", count_frames(0), 0);

        // Load coinciding with the end of latch goes straight to the next frame.
        mask = (64'd1 << wd[1]) - 1;
        w  = {$urandom, $urandom} & mask;
        w2 = {$urandom, $urandom} & mask;
        drive_load(1, w, e0);
        wait_cycles(flen(1) - 1);
        drive_load(1, w2, e_tmp);
        chk("t3c_no_pend", bus1.pend_full, 1'b0);
        chk("t3c_busy", bus1.busy, 1'b1);
        get_frame(1, f, ok);
        check_frame("t3c1", f, 1, w, e0);
        chk("t3c1_busy_held", f.busy_at_done, 1'b1);
        get_frame(1, f, ok);
        check_frame("t3c2", f, 1, w2, e0 + flen(1));

        // Continuous mode: repeat, then replace at the next frame boundary.
        wait_cycles(2);
        drive_load(2, 64'h0F0F, e0);
        busy_low[2] = 0;
        watch[2] = 1'b1;
        wait_cycles(130);
        drive_load(2, 64'h00FF, e_tmp);
        for (int k = 0; k < 4; k++) begin
            get_frame(2, f, ok);
            check_frame("t4", f, 2, (k < 3) ? 64'h0F0F : 64'h00FF, e0 + k * flen(2));
            chk("t4_busy_held", f.busy_at_done, 1'b1);
        end
        watch[2] = 1'b0;
        chk("t4_busy_never_low", busy_low[2], 0);

        // Reset in the middle of a frame.
        mask = (64'd1 << wd[0]) - 1;
        w = {$urandom, $urandom} & mask;
        drive_load(0, w, e0);
        wait_cycles(19);
        chk("t5_oe_low_before_reset", bus0.oe, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_reset_pins_dut0", pins(0), 7'b0000001);
        chk("t5_reset_pins_dut2", pins(2), 7'b0000001);
        wait_cycles(3);
        rst_n = 1'b1;
        fq.delete();
        r0 = tot_rises[0];
        r2 = tot_rises[2];
        wait_cycles(200);
        chk("t5_no_frames_after_reset", fq.size(), 0);
        chk("t5_no_shcp_dut0", tot_rises[0], r0);
        chk("t5_no_shcp_dut2", tot_rises[2], r2);
        chk("t5_idle_pins_dut0", pins(0), 7'b0000001);
        chk("t5_idle_pins_dut2", pins(2), 7'b0000001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
